pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/pipe_ctrl_perf.sv | 23 ++
 rtl/pipe_ctrl.sv | 78 +++++++
 tb/tb_pipe_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM state encoding and default parameters for the pipeline controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, HALT = 2'd2} state_t;
  localparam int NSTAGES_DEF = 5;
  localparam int STALL_STAGE_DEF = 1;
  localparam int BR_FLUSH_DEF = 2;
  localparam int STALL_W_DEF = 3;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating cycle, hold and flush performance counters
module pipe_ctrl_perf #(
  parameter int CNT_W = 32
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush_ev,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(~&cycle_cnt);
      stall_cnt <= stall_cnt + CNT_W'(hold && ~&stall_cnt);
      flush_cnt <= flush_cnt + CNT_W'(flush_ev && ~&flush_cnt);
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/halt controller; perf counters built only with PIPE_CTRL_PERF_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES     = NSTAGES_DEF,
  parameter int STALL_STAGE = STALL_STAGE_DEF,
  parameter int BR_FLUSH    = BR_FLUSH_DEF,
  parameter int STALL_W     = STALL_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_req,
  input  logic [STALL_W-1:0] stall_cycles,
  input  logic               branch_taken,
  input  logic               halt,
  input  logic               resume,
  output logic [NSTAGES-1:0] stage_valid,
  output logic [NSTAGES-1:0] stage_load_en,
  output logic [NSTAGES-1:0] stage_flush,
  output logic               pc_write_en,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  localparam logic [NSTAGES-1:0] ONES = '1;
  localparam logic [NSTAGES-1:0] HOLD_M = ONES >> (NSTAGES - 1 - STALL_STAGE);
  localparam logic [NSTAGES-1:0] BUB_M = NSTAGES'(1) << (STALL_STAGE + 1);
  localparam logic [NSTAGES-1:0] BR_M = ONES >> (NSTAGES - BR_FLUSH);
  state_t st;
  logic [STALL_W-1:0] cnt;
  logic br_ev, hold;
  assign state = st;
  assign br_ev = branch_taken && st != HALT;
  assign hold = !br_ev && (st == STALL || (st == RUN && stall_req));
  assign stage_load_en = (reset || st == HALT) ? '0 : hold ? ~HOLD_M : ONES;
  assign stage_flush = reset ? ONES : br_ev ? BR_M : hold ? BUB_M : '0;
  assign pc_write_en = !reset && st != HALT && !hold;
  // cnt holds remaining STALL cycles; leaving happens on the edge where it reads 1
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= RUN;
      cnt <= '0;
      stage_valid <= '0;
    end else begin
      stage_valid <= (({stage_valid[NSTAGES-2:0], 1'b1} & stage_load_en) | (stage_valid & ~stage_load_en)) & ~stage_flush;
      if (br_ev) begin
        st <= RUN;
        cnt <= '0;
      end else if (st == STALL) begin
        cnt <= cnt - STALL_W'(1);
        if (cnt == STALL_W'(1)) st <= RUN;
      end else if (st == HALT) begin
        if (resume && !halt) st <= RUN;
      end else if (stall_req) begin
        if (stall_cycles > STALL_W'(1)) begin
          st <= STALL;
          cnt <= stall_cycles - STALL_W'(1);
        end
      end else if (halt) st <= HALT;
    end
`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
    .clk(clk),
    .reset(reset),
    .hold(hold),
    .flush_ev(br_ev),
    .cycle_cnt(cycle_cnt),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;
  localparam int NS = 5, SS = 1, BR = 2, SW = 3, CW = 32;
  logic clk = 0, reset = 1, stall_req = 0, branch_taken = 0, halt = 0, resume = 0;
  logic [SW-1:0] stall_cycles = '0;
  logic [NS-1:0] stage_valid, stage_load_en, stage_flush;
  logic pc_write_en;
  logic [1:0] state;
  logic [CW-1:0] cycle_cnt, stall_cnt, flush_cnt;
  int tests = 0, fails = 0;
  logic [NS-1:0] mv;
  bit m_halt;
  int m_left, m_cyc, m_stl, m_fl;
  always #5 clk = ~clk;
  pipe_ctrl #(.NSTAGES(NS), .STALL_STAGE(SS), .BR_FLUSH(BR), .STALL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall_req(stall_req), .stall_cycles(stall_cycles),
    .branch_taken(branch_taken), .halt(halt), .resume(resume),
    .stage_valid(stage_valid), .stage_load_en(stage_load_en), .stage_flush(stage_flush),
    .pc_write_en(pc_write_en), .state(state),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] pc(input int v);
`ifdef PIPE_CTRL_PERF_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction
  task automatic chk_regs();
    chk("state", 64'(state), m_halt ? 64'd2 : (m_left > 0 ? 64'd1 : 64'd0));
    chk("valid", 64'(stage_valid), 64'(mv));
    chk("cycle_cnt", 64'(cycle_cnt), pc(m_cyc));
    chk("stall_cnt", 64'(stall_cnt), pc(m_stl));
    chk("flush_cnt", 64'(flush_cnt), pc(m_fl));
  endtask
  task automatic chk_reset_outs();
    chk("rst_load", 64'(stage_load_en), 64'd0);
    chk("rst_flush", 64'(stage_flush), 64'h1f);
    chk("rst_pc", 64'(pc_write_en), 64'd0);
  endtask
  task automatic do_reset();
    reset = 1;
    #1;
    m_halt = 0; m_left = 0; mv = '0; m_cyc = 0; m_stl = 0; m_fl = 0;
    chk_regs();
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask
  // one clock: check combinational controls, clock, advance model, check registered state
  task automatic step();
    logic [NS-1:0] el, ef, nv;
    bit br, hold;
    int n;
    #1;
    br = branch_taken && !m_halt;
    hold = !br && !m_halt && (m_left > 0 || stall_req);
    for (int i = 0; i < NS; i++) begin
      el[i] = m_halt ? 1'b0 : hold ? (i > SS) : 1'b1;
      ef[i] = br ? (i < BR) : hold ? (i == SS + 1) : 1'b0;
    end
    chk("load_en", 64'(stage_load_en), 64'(el));
    chk("flush", 64'(stage_flush), 64'(ef));
    chk("pc_we", 64'(pc_write_en), 64'(!m_halt && !hold));
    @(posedge clk);
    nv = mv;
    if (!m_halt) begin
      nv[0] = !(br || hold);
      if (hold) nv[0] = mv[0];
      if (br) nv[0] = 1'b0;
      for (int i = 1; i < NS; i++)
        if (br) nv[i] = (i < BR) ? 1'b0 : mv[i-1];
        else if (hold) nv[i] = (i <= SS) ? mv[i] : (i == SS + 1) ? 1'b0 : mv[i-1];
        else nv[i] = mv[i-1];
    end
    mv = nv;
    m_cyc++;
    m_stl += int'(hold);
    m_fl += int'(br);
    n = (stall_cycles == 0) ? 1 : int'(stall_cycles);
    if (br) m_left = 0;
    else if (m_halt) begin
      if (resume && !halt) m_halt = 0;
    end else if (m_left > 0) m_left--;
    else if (stall_req) m_left = n - 1;
    else if (halt) m_halt = 1;
    #1;
    chk_regs();
  endtask
  task automatic drive(input bit s, input int sc, input bit b, input bit h, input bit r);
    stall_req = s; stall_cycles = SW'(sc); branch_taken = b; halt = h; resume = r;
  endtask
  initial begin
    do_reset();
    drive(0, 0, 0, 0, 0);
    repeat (6) step();
    chk("full_pipe", 64'(stage_valid), 64'h1f);
    drive(1, 3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); repeat (3) step();
    drive(1, 2, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0); repeat (3) step();
    drive(1, 4, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 0, 0); step();
    chk("br_in_stall_valid", 64'(stage_valid[1:0]), 64'd0);
    drive(0, 0, 0, 0, 0); repeat (3) step();
    drive(1, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0); step();
    drive(0, 0, 1, 0, 0); step();
    drive(1, 5, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); repeat (2) step();
    drive(0, 0, 0, 1, 1); step();
    drive(0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0); repeat (2) step();
    drive(1, 5, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    reset = 1;
    #1;
    m_halt = 0; m_left = 0; mv = '0; m_cyc = 0; m_stl = 0; m_fl = 0;
    chk_regs();
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (400) begin
      if ($urandom_range(99) == 0) do_reset();
      drive($urandom_range(3) == 0, int'($urandom_range(7)), $urandom_range(7) == 0,
            $urandom_range(9) == 0, $urandom_range(2) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
